pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the XPU core.
- Successor to the fixed-field stage registers. Carries one packed payload of DATA_W bits plus a PC, and adds:
  - valid/ready handshake with a 2-entry skid buffer, so upstream ready is fully registered;
  - a Flush mode;
  - a stall-cycle counter.
- Sits between any two stages (IF/ID, ID/EX, EX/MEM). The pipeline controller drives ctrl_signal_i.

Parameters:
- DATA_W, 128: packed payload width (opcode, funct, operands, rd, imm, ...).
- ADDR_W, 64: PC width.
- BUBBLE_DATA, {DATA_W{1'b0}}: payload injected on Bubble. For ID/EX this is the packed addi x0,x0,0 encoding.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (rst==0 resets).
- ctrl_signal_i  in  `CTRL_Wire_Bus  Default / Stalled / Bubble / Flush.
- in_valid_i  in  1  upstream payload valid.
- in_ready_o  out  1  stage can accept (registered).
- in_data_i  in  DATA_W  upstream payload.
- in_pc_i  in  ADDR_W  upstream PC.
- out_valid_o  out  1  downstream payload valid.
- out_ready_i  in  1  downstream accepts.
- out_data_o  out  DATA_W  registered payload.
- out_pc_o  out  ADDR_W  registered PC.
- stall_cnt_o  out  CNT_W  consecutive Stalled cycles, saturating.

Behaviour:
- Reset (rst low, async):
  - main and skid entries invalid; out_valid_o=0, in_ready_o=1;
  - out_data_o=BUBBLE_DATA, out_pc_o=0, stall_cnt_o=0.
  - Reset mid-transfer discards both entries.
- Storage: main entry (drives outputs) plus skid entry.
  - in_ready_o is registered and equals !skid_valid.
- Transfer definitions: input transfer = in_valid_i & in_ready_o; output transfer = out_valid_o & out_ready_i.
- Default mode:
  - Main empty, or main drained this cycle: input transfer loads main; 1-cycle latency.
  - Main full, not draining, input transfer: payload goes to skid; in_ready_o falls next cycle.
  - Main drains with skid valid: skid moves to main, skid is freed, in_ready_o rises next cycle.
  - Simultaneous drain and fill with skid empty: main takes the new payload, with no bubble between.
- Stalled mode:
  - Both entries frozen.
  - out_valid_o is held, but out_ready_i is ignored: no output transfer.
  - Input transfer is still permitted only into an empty skid entry, so an in-flight handshake is not lost.
  - stall_cnt_o increments and saturates at all-ones.
- Bubble mode:
  - If main is empty or draining, main loads BUBBLE_DATA with out_pc_o=in_pc_i and out_valid_o=1 next cycle.
  - No input is consumed (effective in_ready low); skid is unchanged.
  - If main is full and not draining, the bubble is deferred; Bubble mode behaves as Stalled for the entries but the counter does not advance.
- Flush mode:
  - Next cycle, both entries are invalid, out_valid_o=0, in_ready_o=1.
  - Any same-cycle input is discarded.
  - out_data_o returns to BUBBLE_DATA.
- Unrecognised ctrl encodings are treated as Flush.
- stall_cnt_o clears to 0 on the first cycle in any mode other than Stalled.
- Data ordering is strictly FIFO across main and skid; no payload is duplicated or dropped except by Flush or reset.

Decomposition:
- `defines.v` gains `CTRL_STATE_Flush` alongside the existing Default/Stalled/Bubble encodings and `CTRL_Wire_Bus`.
- Per-stage BUBBLE_DATA constants live there too, e.g. `ID_EX_NOP_PAYLOAD`.
- One sub-module: pipe_skid_entry, a valid+data+pc register with load/clear, instantiated twice.
- The existing Reg primitive is not reused, because it has a synchronous reset.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release -> out_valid_o=0, in_ready_o=1, stall_cnt_o=0, out_pc_o=0.
- Streaming: Default mode, out_ready_i=1, inputs D0..D3 on consecutive cycles -> D0..D3 appear 1 cycle later, back-to-back, no gaps.
- Backpressure:
  - Stimulus: Default mode, out_ready_i=0; send D0 and D1.
  - Response: D0 held in main; in_ready_o=0 from the cycle after D1 is accepted.
  - Stimulus: raise out_ready_i.
  - Response: D0 then D1 appear, and in_ready_o returns to 1 one cycle after D1 moves to main.
- Stall counter: 5 cycles of Stalled -> outputs frozen, stall_cnt_o=5. With CNT_W=3 and 10 Stalled cycles -> stall_cnt_o=7; then Default -> 0.
- Bubble:
  - Stimulus: main empty, Bubble with in_pc_i=0x8000_0010.
  - Response: next cycle out_data_o=BUBBLE_DATA, out_pc_o=0x8000_0010, out_valid_o=1; upstream payload not consumed.
- Flush with both entries full -> next cycle out_valid_o=0, in_ready_o=1; the discarded payloads never appear at the output.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared control encodings and per-stage bubble payloads for the pipeline stage registers.
package pipe_stage_reg_pkg;

  localparam int CTRL_W = 3;

  typedef enum logic [CTRL_W-1:0] {
    CTRL_DEFAULT = 3'd0,
    CTRL_STALLED = 3'd1,
    CTRL_BUBBLE  = 3'd2,
    CTRL_FLUSH   = 3'd3
  } ctrl_e;

  // Packed addi x0,x0,0 used as the ID/EX bubble payload.
  localparam logic [31:0] ID_EX_NOP_PAYLOAD = 32'h0000_0013;

  // Any encoding outside the known set is safest treated as a flush.
  function automatic ctrl_e decode_ctrl(input logic [CTRL_W-1:0] raw);
    case (raw)
      3'd0:    return CTRL_DEFAULT;
      3'd1:    return CTRL_STALLED;
      3'd2:    return CTRL_BUBBLE;
      default: return CTRL_FLUSH;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// One pipeline slot: valid flag plus payload and PC, with set / drop / clear controls.
module pipe_skid_entry #(
  parameter int                DATA_W   = 128,
  parameter int                ADDR_W   = 64,
  parameter logic [DATA_W-1:0] CLR_DATA = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_i,
  input  logic              drop_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] pc_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  // Drop keeps the old payload visible; only clear restores the idle payload.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (clear_i) begin
      valid_d = 1'b0;
      data_d  = CLR_DATA;
      pc_d    = '0;
    end else if (set_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      pc_d    = pc_i;
    end else if (drop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= CLR_DATA;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: main slot plus skid slot, registered upstream ready,
// Default/Stalled/Bubble/Flush control and a saturating stall-cycle counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W      = 128,
  parameter int                ADDR_W      = 64,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = {DATA_W{1'b0}},
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] ctrl_signal_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [ADDR_W-1:0] in_pc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [ADDR_W-1:0] out_pc_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  ctrl_e             mode;
  logic              main_v, skid_v;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [ADDR_W-1:0] main_pc, skid_pc;
  logic              drain, main_free, in_xfer;
  logic              main_set, main_drop, skid_set, skid_drop, flush;
  logic [DATA_W-1:0] main_din;
  logic [ADDR_W-1:0] main_pcin;
  logic              skid_v_d;
  logic              in_ready_q;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  assign mode      = decode_ctrl(ctrl_signal_i);
  assign drain     = main_v & out_ready_i & ((mode == CTRL_DEFAULT) | (mode == CTRL_BUBBLE));
  assign main_free = ~main_v | drain;
  assign in_xfer   = in_valid_i & in_ready_q & ((mode == CTRL_DEFAULT) | (mode == CTRL_STALLED));

  always_comb begin
    main_set  = 1'b0;
    main_drop = 1'b0;
    skid_set  = 1'b0;
    skid_drop = 1'b0;
    flush     = 1'b0;
    main_din  = in_data_i;
    main_pcin = in_pc_i;
    case (mode)
      CTRL_DEFAULT: begin
        // The skid slot always holds the older payload, so it refills main first.
        if (skid_v) begin
          if (main_free) begin
            main_set  = 1'b1;
            main_din  = skid_data;
            main_pcin = skid_pc;
            skid_drop = 1'b1;
          end
        end else if (main_free) begin
          if (in_xfer) main_set = 1'b1;
          else         main_drop = 1'b1;
        end else if (in_xfer) begin
          skid_set = 1'b1;
        end
      end
      CTRL_STALLED: skid_set = in_xfer;
      CTRL_BUBBLE: begin
        if (main_free) begin
          main_set = 1'b1;
          main_din = BUBBLE_DATA;
        end
      end
      default: flush = 1'b1;
    endcase
  end

  assign skid_v_d = skid_set | (skid_v & ~skid_drop & ~flush);

  always_comb begin
    stall_cnt_d = '0;
    if (mode == CTRL_STALLED)
      stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      in_ready_q  <= ~skid_v_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  pipe_skid_entry #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .CLR_DATA(BUBBLE_DATA)
  ) u_main (
    .clk    (clk),
    .rst_n  (rst),
    .set_i  (main_set),
    .drop_i (main_drop),
    .clear_i(flush),
    .data_i (main_din),
    .pc_i   (main_pcin),
    .valid_o(main_v),
    .data_o (main_data),
    .pc_o   (main_pc)
  );

  pipe_skid_entry #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .CLR_DATA({DATA_W{1'b0}})
  ) u_skid (
    .clk    (clk),
    .rst_n  (rst),
    .set_i  (skid_set),
    .drop_i (skid_drop),
    .clear_i(flush),
    .data_i (in_data_i),
    .pc_i   (in_pc_i),
    .valid_o(skid_v),
    .data_o (skid_data),
    .pc_o   (skid_pc)
  );

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = main_v;
  assign out_data_o  = main_data;
  assign out_pc_o    = main_pc;
  assign stall_cnt_o = stall_cnt_q;

endmodule
